// File: rtl/sd_pkg.sv
// sd_pkg: shared constants, state encoding and fixed-CRC table for the SD SPI command transmitter
package sd_pkg;
  localparam int FRAME_BITS = 48;
  localparam int PAYLOAD_BITS = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD8 = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  typedef enum logic [2:0] {IDLE, SHIFT, CRC, GAP, DONE} state_t;
  // Only CMD0 and CMD8 are CRC-checked in SPI mode; everything else gets all-ones
  function automatic logic [6:0] crc_table(input logic [5:0] c, input logic [31:0] a);
    return (c == CMD0) ? 7'h4A : (c == CMD8 && a == 32'h0000_01AA) ? 7'h43 : 7'h7F;
  endfunction
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: one-bit serial CRC7 (x^7+x^3+1), built only when SD_CMD_CRC_EN is defined
`ifdef SD_CMD_CRC_EN
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic fb;
  assign fb = din ^ crc[6];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
endmodule
`endif

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: SPI-mode SD 48-bit command serialiser with CS control and idle gap.
// SD_CMD_CRC_EN selects a live CRC7 generator instead of the fixed CRC table.
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  input  logic        cs_hold,
  output logic        DI,
  output logic        CS,
  output logic        busy,
  output logic        done,
  output logic [5:0]  cmd_out
);
  state_t state, next;
  logic [PAYLOAD_BITS-1:0] sr;
  logic [5:0] cnt;
  logic [7:0] gcnt;
  logic [6:0] crc_val;
  logic accept;
  assign busy = (state == SHIFT) || (state == CRC) || (state == GAP);
  assign done = (state == DONE);
  assign accept = start && !busy;
  assign DI = (state == SHIFT) ? sr[PAYLOAD_BITS-1] :
              (state == CRC && cnt < 6'd7) ? crc_val[3'd6 - cnt[2:0]] : 1'b1;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? SHIFT : IDLE;
      SHIFT:   next = (cnt == 6'(PAYLOAD_BITS - 1)) ? CRC : SHIFT;
      CRC:     next = (cnt == 6'd7) ? GAP : CRC;
      GAP:     next = (gcnt == 8'(GAP_CYCLES - 1)) ? DONE : GAP;
      DONE:    next = start ? SHIFT : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      cmd_out <= '0;
      CS      <= 1'b1;
    end else begin
      state <= next;
      CS    <= (next == IDLE) ? !cs_hold : 1'b0;
      if (accept) begin
        sr      <= {2'b01, cmd, arg};
        cmd_out <= cmd;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        sr  <= {sr[PAYLOAD_BITS-2:0], 1'b0};
        cnt <= (cnt == 6'(PAYLOAD_BITS - 1)) ? 6'd0 : cnt + 6'd1;
      end else if (state == CRC) begin
        cnt  <= cnt + 6'd1;
        gcnt <= '0;
      end else if (state == GAP) begin
        gcnt <= gcnt + 8'd1;
      end
    end
`ifdef SD_CMD_CRC_EN
  sd_crc7 u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state == SHIFT),
    .din  (sr[PAYLOAD_BITS-1]),
    .crc  (crc_val)
  );
`else
  // Table CRC is resolved at accept time since the argument is shifted away afterwards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_val <= '0;
    else if (accept) crc_val <= crc_table(cmd, arg);
`endif
endmodule
